// File: rtl/safe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : safe_pkg
// Description : Shared types and constants for the keypad safe: controller
//               state encoding, key-code values, seven-segment patterns and
//               a helper that maps a state to its display pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package safe_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROGRAM = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Key codes; 0-9 are digits, E and F are never acted upon.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_LOCK      = 4'hC;
  localparam logic [3:0] KEY_PROG      = 4'hD;

  // Active-low segment patterns.
  localparam logic [6:0] SEG_L    = 7'b1000111;
  localparam logic [6:0] SEG_U    = 7'b1000001;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] seg_for_state(input state_e st);
    logic [6:0] seg;
    seg = SEG_L;
    case (st)
      ST_LOCKED:  seg = SEG_L;
      ST_OPEN:    seg = SEG_U;
      ST_PROGRAM: seg = SEG_P;
      ST_LOCKOUT: seg = SEG_DASH;
      default:    seg = SEG_L;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/safe_lockout_timer.sv
`default_nettype none
// ============================================================================
// Module      : safe_lockout_timer
// Description : Lockout down-counter. A start strobe loads CYCLES; done_o
//               pulses for one cycle in the last cycle of the interval, so a
//               state entered on the start edge and left on the edge after
//               done_o lasts exactly CYCLES cycles.
// Ports       : clock    - clock
//               reset_n  - asynchronous active-low reset
//               start_i  - load the counter (takes effect on the next edge)
//               done_o   - one-cycle pulse, final cycle of the interval
// Revision    : 1.0 - initial release
// ============================================================================
module safe_lockout_timer #(
  parameter int CYCLES = 1000,
  localparam int W = $clog2(CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  output logic done_o
);

  localparam logic [W-1:0] LOAD_VAL = CYCLES[W-1:0];
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == ONE);

endmodule
`default_nettype wire

// File: rtl/safe_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : safe_keypad_entry
// Description : Keypad-operated safe controller. Collects four-digit codes,
//               opens on a match, locks out after MAX_FAIL consecutive bad
//               entries and allows the code to be reprogrammed while open.
// Ports       : clock      - clock, all state changes on rising edge
//               reset_n    - asynchronous active-low reset
//               key_valid  - one-cycle key strobe
//               key_code   - 0-9 digit, A enter, B clear, C lock, D prog
//               unlocked   - high in OPEN
//               lockout    - high in LOCKOUT
//               fail_count - consecutive failure count
//               display    - active-low seven-segment status pattern
// Revision    : 1.0 - initial release
// ============================================================================
module safe_keypad_entry
  import safe_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_count,
  output logic [6:0] display
);

  // fail_count is two bits wide, so MAX_FAIL is meaningful up to 3.
  localparam logic [1:0] FAIL_LIMIT = MAX_FAIL[1:0];

  state_e      state_q,    state_d;
  logic [15:0] entry_q,    entry_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [1:0]  fail_q,     fail_d;
  logic [15:0] code_q,     code_d;
  logic        unlocked_q, lockout_q;
  logic [6:0]  display_q;

  logic        timer_start;
  logic        timer_done;
  logic        is_digit;
  logic [1:0]  fail_inc;

  assign is_digit = key_valid && (key_code <= KEY_DIGIT_MAX);
  assign fail_inc = fail_q + 2'd1;

  safe_lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .start_i (timer_start),
    .done_o  (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    digit_cnt_d = digit_cnt_q;
    fail_d      = fail_q;
    code_d      = code_q;
    timer_start = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (is_digit) begin
          if (digit_cnt_q != 3'd4) begin
            entry_d     = {entry_q[11:0], key_code};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end else if (key_valid && key_code == KEY_CLEAR) begin
          entry_d     = '0;
          digit_cnt_d = '0;
        end else if (key_valid && key_code == KEY_ENTER) begin
          entry_d     = '0;
          digit_cnt_d = '0;
          if (digit_cnt_q == 3'd4 && entry_q == code_q) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_d     = ST_LOCKOUT;
              timer_start = 1'b1;
            end
          end
        end
      end

      ST_OPEN: begin
        if (key_valid && key_code == KEY_LOCK) begin
          state_d = ST_LOCKED;
        end else if (key_valid && key_code == KEY_PROG) begin
          state_d     = ST_PROGRAM;
          entry_d     = '0;
          digit_cnt_d = '0;
        end
      end

      ST_PROGRAM: begin
        if (is_digit) begin
          if (digit_cnt_q != 3'd4) begin
            entry_d     = {entry_q[11:0], key_code};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end else if (key_valid && key_code == KEY_ENTER) begin
          // A short entry is discarded but the user stays in PROGRAM.
          if (digit_cnt_q == 3'd4) begin
            code_d  = entry_q;
            state_d = ST_OPEN;
          end
          entry_d     = '0;
          digit_cnt_d = '0;
        end else if (key_valid && key_code == KEY_CLEAR) begin
          state_d     = ST_OPEN;
          entry_d     = '0;
          digit_cnt_d = '0;
        end
      end

      ST_LOCKOUT: begin
        if (timer_done) begin
          state_d     = ST_LOCKED;
          fail_d      = '0;
          entry_d     = '0;
          digit_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOCKED;
      entry_q     <= '0;
      digit_cnt_q <= '0;
      fail_q      <= '0;
      code_q      <= DEFAULT_CODE;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
      display_q   <= SEG_L;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      digit_cnt_q <= digit_cnt_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
      // Outputs are decoded from the next state so they change on the same
      // edge as the state register rather than one cycle later.
      unlocked_q  <= (state_d == ST_OPEN);
      lockout_q   <= (state_d == ST_LOCKOUT);
      display_q   <= seg_for_state(state_d);
    end
  end

  assign unlocked   = unlocked_q;
  assign lockout    = lockout_q;
  assign fail_count = fail_q;
  assign display    = display_q;

endmodule
`default_nettype wire

// File: tb/tb_safe_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_safe_keypad_entry
// Description : Self-checking bench for safe_keypad_entry. Table of key
//               vectors with expected outputs, plus hand-written sequences
//               for lockout timing and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_safe_keypad_entry;

  localparam logic [6:0] S_L = 7'b1000111;
  localparam logic [6:0] S_U = 7'b1000001;
  localparam logic [6:0] S_P = 7'b0001100;
  localparam logic [6:0] S_D = 7'b0111111;
  localparam logic [3:0] K_ENT = 4'hA;
  localparam logic [3:0] K_CLR = 4'hB;
  localparam logic [3:0] K_LCK = 4'hC;
  localparam logic [3:0] K_PRG = 4'hD;
  localparam int         LOCK_CYC = 1000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_count;
  logic [6:0] display;

  safe_keypad_entry #(
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAIL       (3),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .fail_count (fail_count),
    .display    (display)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [3:0] k;
    logic       u;
    logic       lo;
    logic [1:0] f;
    logic [6:0] d;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(input logic [3:0] k, input logic u, input logic lo,
                              input logic [1:0] f, input logic [6:0] d);
    vec_t t;
    t.v = 1'b1; t.k = k; t.u = u; t.lo = lo; t.f = f; t.d = d;
    return t;
  endfunction

  task automatic check_out(input string name);
    vec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (unlocked === e.u && lockout === e.lo && fail_count === e.f && display === e.d) begin
        passes++;
      end else begin
        $display("FAIL %s: got u=%b lo=%b f=%0d d=%b, want u=%b lo=%b f=%0d d=%b",
                 name, unlocked, lockout, fail_count, display, e.u, e.lo, e.f, e.d);
      end
    end
  endtask

  // Drive one key for one cycle and compare the outputs after the edge.
  task automatic apply(input vec_t t, input string name);
    @(negedge clock);
    key_valid = t.v;
    key_code  = t.k;
    exp_q.push_back(t);
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    check_out(name);
  endtask

  task automatic expect_now(input logic u, input logic lo, input logic [1:0] f,
                            input logic [6:0] d, input string name);
    exp_q.push_back(mk(4'h0, u, lo, f, d));
    check_out(name);
  endtask

  task automatic key(input logic [3:0] k, input logic u, input logic lo,
                     input logic [1:0] f, input logic [6:0] d, input string name);
    apply(mk(k, u, lo, f, d), name);
  endtask

  // Four wrong digits then ENTER from LOCKED with the given prior count.
  task automatic wrong_entry(input logic [1:0] prev, input string name);
    for (int i = 0; i < 4; i++) key(4'h1, 1'b0, 1'b0, prev, S_L, name);
    if (prev == 2'd2) key(K_ENT, 1'b0, 1'b1, 2'd3, S_D, name);
    else              key(K_ENT, 1'b0, 1'b0, prev + 2'd1, S_L, name);
  endtask

  task automatic enter_code(input logic [15:0] c, input logic [1:0] f, input string name);
    for (int i = 3; i >= 0; i--) key(c[i*4 +: 4], 1'b0, 1'b0, f, S_L, name);
    key(K_ENT, 1'b1, 1'b0, 2'd0, S_U, name);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    expect_now(1'b0, 1'b0, 2'd0, S_L, name);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Main table: starts from reset with code 1234.
    tbl.push_back(mk(4'h1, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h2, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h3, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h4, 0, 0, 0, S_L));
    tbl.push_back(mk(K_ENT, 1, 0, 0, S_U));   // correct code opens
    tbl.push_back(mk(4'hE, 1, 0, 0, S_U));    // ignored in OPEN
    tbl.push_back(mk(4'h7, 1, 0, 0, S_U));    // digit ignored in OPEN
    tbl.push_back(mk(K_LCK, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h1, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h2, 0, 0, 0, S_L));
    tbl.push_back(mk(K_ENT, 0, 0, 1, S_L));   // short entry is a failure
    tbl.push_back(mk(4'h1, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h2, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h3, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h4, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h5, 0, 0, 1, S_L));    // fifth digit ignored
    tbl.push_back(mk(K_ENT, 1, 0, 0, S_U));
    tbl.push_back(mk(K_PRG, 0, 0, 0, S_P));
    tbl.push_back(mk(4'h9, 0, 0, 0, S_P));
    tbl.push_back(mk(4'h8, 0, 0, 0, S_P));
    tbl.push_back(mk(4'h7, 0, 0, 0, S_P));
    tbl.push_back(mk(4'h6, 0, 0, 0, S_P));
    tbl.push_back(mk(K_ENT, 1, 0, 0, S_U));   // new code 9876 stored
    tbl.push_back(mk(K_LCK, 0, 0, 0, S_L));
    tbl.push_back(mk(K_PRG, 0, 0, 0, S_L));   // PROG outside OPEN: no effect
    tbl.push_back(mk(4'h1, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h2, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h3, 0, 0, 0, S_L));
    tbl.push_back(mk(4'h4, 0, 0, 0, S_L));
    tbl.push_back(mk(K_ENT, 0, 0, 1, S_L));   // old code now fails
    tbl.push_back(mk(4'h5, 0, 0, 1, S_L));
    tbl.push_back(mk(K_CLR, 0, 0, 1, S_L));   // CLEAR keeps fail_count
    tbl.push_back(mk(4'h9, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h8, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h7, 0, 0, 1, S_L));
    tbl.push_back(mk(4'h6, 0, 0, 1, S_L));
    tbl.push_back(mk(K_ENT, 1, 0, 0, S_U));   // new code opens
    tbl.push_back(mk(K_PRG, 0, 0, 0, S_P));
    tbl.push_back(mk(4'h1, 0, 0, 0, S_P));
    tbl.push_back(mk(K_ENT, 0, 0, 0, S_P));   // short program entry stays
    tbl.push_back(mk(K_CLR, 1, 0, 0, S_U));   // abandon programming

    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    expect_now(1'b0, 1'b0, 2'd0, S_L, "reset_state");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset after reprogramming restores 1234.
    pulse_reset("reset_after_prog");
    enter_code(16'h1234, 2'd0, "default_after_reset");

    // PROG,5,CLEAR leaves the code unchanged.
    key(K_PRG, 1'b0, 1'b0, 2'd0, S_P, "prog_abort");
    key(4'h5,  1'b0, 1'b0, 2'd0, S_P, "prog_abort");
    key(K_CLR, 1'b1, 1'b0, 2'd0, S_U, "prog_abort");
    key(K_LCK, 1'b0, 1'b0, 2'd0, S_L, "prog_abort");
    enter_code(16'h1234, 2'd0, "code_unchanged");

    // Three failures lock out for exactly LOCK_CYC cycles.
    key(K_LCK, 1'b0, 1'b0, 2'd0, S_L, "relock");
    wrong_entry(2'd0, "fail1");
    wrong_entry(2'd1, "fail2");
    wrong_entry(2'd2, "fail3");
    key(4'h1,  1'b0, 1'b1, 2'd3, S_D, "lockout_key");
    key(K_ENT, 1'b0, 1'b1, 2'd3, S_D, "lockout_key");
    key(K_LCK, 1'b0, 1'b1, 2'd3, S_D, "lockout_key");
    repeat (LOCK_CYC - 1 - 3) @(posedge clock);
    #1;
    expect_now(1'b0, 1'b1, 2'd3, S_D, "lockout_last_cycle");
    @(posedge clock);
    #1;
    expect_now(1'b0, 1'b0, 2'd0, S_L, "lockout_expired");
    enter_code(16'h1234, 2'd0, "after_lockout");

    // Reset mid-lockout returns straight to LOCKED.
    key(K_LCK, 1'b0, 1'b0, 2'd0, S_L, "relock2");
    wrong_entry(2'd0, "fail1b");
    wrong_entry(2'd1, "fail2b");
    wrong_entry(2'd2, "fail3b");
    repeat (10) @(posedge clock);
    pulse_reset("reset_in_lockout");
    enter_code(16'h1234, 2'd0, "after_lockout_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
